// File: rtl/flags_pkg.sv
// Shared types and constants for the status-flag register.
// Flag vector layout, MSB to LSB: {OF, SF, ZF, PF, CF}.
package flags_pkg;

  localparam int unsigned FLAG_CF = 0;
  localparam int unsigned FLAG_PF = 1;
  localparam int unsigned FLAG_ZF = 2;
  localparam int unsigned FLAG_SF = 3;
  localparam int unsigned FLAG_OF = 4;

  typedef logic [4:0] flags_t;

  localparam flags_t FLAGS_RST = 5'b0;

endpackage

// File: rtl/parity_gen.sv
// Even-parity generator over one byte: 1 when the number of ones is even.
module parity_gen (
  input  logic [7:0] data,
  output logic       parity
);

  // XNOR-reduce yields 1 for an even count of ones
  assign parity = ~(^data);

endmodule

// File: rtl/flags_register.sv
// Status-flag register placed after the ALU. Captures ZF, SF, CF, OF and PF
// on update_flags and holds them for the branch/condition logic.
// Optional macro FLAGS_LOAD_EN adds a direct flag write port (load_flags,
// load_value) that takes priority over update_flags.
module flags_register
  import flags_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             carry_in,
  input  logic             overflow_in,
  input  logic             update_flags,
`ifdef FLAGS_LOAD_EN
  input  logic             load_flags,
  input  logic [4:0]       load_value,
`endif
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             parity_flag
);

  flags_t flags_d, flags_q;
  logic   parity;

  // PF follows the 8086 rule: low byte only, regardless of WIDTH
  parity_gen u_parity_gen (
    .data   (alu_result[7:0]),
    .parity (parity)
  );

  // Next-state selection: load beats update, otherwise hold
  always_comb begin
    flags_d = flags_q;
`ifdef FLAGS_LOAD_EN
    if (load_flags) begin
      flags_d = flags_t'(load_value);
    end else
`endif
    if (update_flags) begin
      flags_d[FLAG_ZF] = (alu_result == '0);
      flags_d[FLAG_SF] = alu_result[WIDTH-1];
      flags_d[FLAG_CF] = carry_in;
      flags_d[FLAG_OF] = overflow_in;
      flags_d[FLAG_PF] = parity;
    end
  end

  // Flag register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= FLAGS_RST;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign zero_flag     = flags_q[FLAG_ZF];
  assign sign_flag     = flags_q[FLAG_SF];
  assign carry_flag    = flags_q[FLAG_CF];
  assign overflow_flag = flags_q[FLAG_OF];
  assign parity_flag   = flags_q[FLAG_PF];

endmodule

// File: tb/tb_flags_register.sv
// Self-checking bench for flags_register (WIDTH=8, default build).
`timescale 1ns/1ps
module tb_flags_register;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_result;
  logic       carry_in;
  logic       overflow_in;
  logic       update_flags;
  logic       zero_flag, sign_flag, carry_flag, overflow_flag, parity_flag;
`ifdef FLAGS_LOAD_EN
  logic       load_flags = 1'b0;
  logic [4:0] load_value = 5'b0;
`endif

  flags_register #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_result    (alu_result),
    .carry_in      (carry_in),
    .overflow_in   (overflow_in),
    .update_flags  (update_flags),
`ifdef FLAGS_LOAD_EN
    .load_flags    (load_flags),
    .load_value    (load_value),
`endif
    .zero_flag     (zero_flag),
    .sign_flag     (sign_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .parity_flag   (parity_flag)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] model;
  logic [4:0] exp_q[$];

  // Observed flags packed as {OF, SF, ZF, PF, CF}
  function automatic logic [4:0] observed();
    return {overflow_flag, sign_flag, zero_flag, parity_flag, carry_flag};
  endfunction

  // Reference flag derivation, parity by explicit counting
  function automatic logic [4:0] derive(logic [7:0] r, logic c, logic o);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(r[i]);
    return {o, r[7], (r == 8'h00), ((ones % 2) == 0), c};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got {OF,SF,ZF,PF,CF}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Compare whatever the DUT shows now against the oldest queued expectation
  task automatic compare_now(input string tag);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got %b expected a queued value", tag, observed());
    end else begin
      check(tag, observed(), exp_q.pop_front());
    end
  endtask

  // Drive one cycle of inputs, predict, then check just after the rising edge
  task automatic apply(input string tag, input logic [7:0] r, input logic c, input logic o,
                       input logic u);
    @(negedge clk);
    alu_result   = r;
    carry_in     = c;
    overflow_in  = o;
    update_flags = u;
    if (u) model = derive(r, c, o);
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    compare_now(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    alu_result   = 8'h00;
    carry_in     = 1'b0;
    overflow_in  = 1'b0;
    update_flags = 1'b0;
    model        = 5'b0;
    #10;
    exp_q.push_back(5'b0);
    compare_now("reset_async");
    @(negedge clk);
    rst = 1'b0;

    // Flags stay clear after release until a capture
    for (int i = 0; i < 2; i++) apply("post_reset_hold", 8'hA5, 1'b1, 1'b1, 1'b0);

    apply("zero_result",  8'h00, 1'b0, 1'b0, 1'b1);
    apply("sign_result",  8'h80, 1'b0, 1'b0, 1'b1);
    apply("all_ones",     8'hFF, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) apply("hold", 8'h00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges, with a capture pending
    @(negedge clk);
    alu_result   = 8'h03;
    carry_in     = 1'b0;
    overflow_in  = 1'b0;
    update_flags = 1'b1;
    rst          = 1'b1;
    #1;
    model = 5'b0;
    exp_q.push_back(model);
    compare_now("rst_midstream");
    #1;
    rst = 1'b0;
    model = derive(8'h03, 1'b0, 1'b0);
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    compare_now("after_rst_capture");

    // Continuous update and mixed hold with random data
    for (int i = 0; i < 40; i++) begin
      apply("random", 8'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
